// File: rtl/quad_paddle_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : quad_paddle_decoder
//  Purpose  : Turns the raw quadrature channels of the paddle encoder into a
//             filtered, saturating paddle position. Both channels are
//             synchronised and glitch-filtered, Gray-code steps are decoded
//             (with optional double-step acceleration), illegal two-bit
//             transitions raise a sticky error, and a frame-stable copy of
//             the position is latched on the frame strobe.
//  Ports    : clk              system clock
//             resetn           asynchronous active-low reset
//             quad_a, quad_b   raw encoder channels (asynchronous to clk)
//             frame_strobe     one-cycle pulse per video frame
//             err_clr          clears quad_err
//             paddle_pos       live position
//             paddle_pos_frame position latched on frame_strobe
//             step_valid       one-cycle pulse per legal step
//             step_dir         direction of last legal step (1 = increment)
//             quad_err         sticky illegal-transition flag
//  Revision : 1.0  initial release
// ============================================================================
module quad_paddle_decoder #(
  parameter int FILTER_LEN  = 4,
  parameter int POS_WIDTH   = 9,
  parameter int POS_MAX     = 511,
  parameter int POS_RESET   = 0,
  parameter int FAST_WINDOW = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 quad_a,
  input  logic                 quad_b,
  input  logic                 frame_strobe,
  input  logic                 err_clr,
  output logic [POS_WIDTH-1:0] paddle_pos,
  output logic [POS_WIDTH-1:0] paddle_pos_frame,
  output logic                 step_valid,
  output logic                 step_dir,
  output logic                 quad_err
);

  localparam int C_CNT_W = 4;
  localparam int C_IVL_W = 10;
  localparam int C_EXT_W = POS_WIDTH + 1;

  localparam logic [C_CNT_W-1:0]   C_FLT_LEN   = C_CNT_W'(FILTER_LEN);
  localparam logic [C_IVL_W-1:0]   C_FAST_WIN  = C_IVL_W'(FAST_WINDOW);
  localparam bit                   C_ACCEL_EN  = (FAST_WINDOW > 0);
  localparam logic [C_EXT_W-1:0]   C_POS_MAX_X = C_EXT_W'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] C_POS_MAX   = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] C_POS_RESET = POS_WIDTH'(POS_RESET);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Channel pairs are kept as {a, b}: bit 1 = a, bit 0 = b.
  state_e               state_q, state_d;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           pair_last_q;
  logic [C_CNT_W-1:0]   stab_cnt_q, stab_cnt_d, stab_inc;
  logic                 load_init;
  logic [1:0]           filt_q, filt_d;
  logic [1:0]           prev_q, prev_d;
  logic [C_IVL_W-1:0]   ivl_q, ivl_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d, pos_frame_q;
  logic                 step_valid_q, step_dir_q, err_q;

  logic [1:0]           changed;
  logic                 decode, legal, illegal, dir, fast;
  logic [POS_WIDTH-1:0] step_sz, diff, pos_step;
  logic [C_EXT_W-1:0]   sum_ext;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pair_last_q <= '0;
    end else begin
      sync1_q     <= {quad_a, quad_b};
      sync2_q     <= sync1_q;
      pair_last_q <= sync2_q;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: INIT waits for the synchronised pair to be stable for FILTER_LEN
  // cycles before seeding the filter and previous state, so the encoder's
  // resting position at power-up never produces a step or an error.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INIT;
      stab_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign stab_inc = stab_cnt_q + C_CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    load_init  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (sync2_q != pair_last_q) begin
          stab_cnt_d = '0;
        end else if (stab_inc == C_FLT_LEN) begin
          stab_cnt_d = '0;
          load_init  = 1'b1;
          state_d    = ST_RUN;
        end else begin
          stab_cnt_d = stab_inc;
        end
      end
      ST_RUN: begin
        stab_cnt_d = '0;
      end
      default: begin
        state_d    = ST_INIT;
        stab_cnt_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-channel glitch filter: the filtered bit only follows sync2 after it
  // has disagreed for FILTER_LEN consecutive cycles.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [C_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic               filt_nxt;

    assign cnt_inc = cnt_q + C_CNT_W'(1);

    always_comb begin
      cnt_d    = cnt_q;
      filt_nxt = filt_q[gi];
      if (state_q == ST_INIT) begin
        cnt_d = '0;
        if (load_init) begin
          filt_nxt = sync2_q[gi];
        end
      end else if (sync2_q[gi] == filt_q[gi]) begin
        cnt_d = '0;
      end else if (cnt_inc == C_FLT_LEN) begin
        filt_nxt = sync2_q[gi];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign filt_d[gi] = filt_nxt;
  end

  // --------------------------------------------------------------------------
  // Decode, acceleration and saturating position arithmetic
  // --------------------------------------------------------------------------
  always_comb begin
    changed = filt_q ^ prev_q;
    decode  = (state_q == ST_RUN) && (changed != 2'b00);
    legal   = decode && (changed != 2'b11);
    illegal = decode && (changed == 2'b11);
    // Forward Gray order 00->01->11->10->00 always has prev_a XOR new_b = 1.
    dir     = prev_q[1] ^ filt_q[0];

    fast    = C_ACCEL_EN && (dir == step_dir_q) && (ivl_q < C_FAST_WIN);
    step_sz = fast ? POS_WIDTH'(2) : POS_WIDTH'(1);

    // Increment is done one bit wider so overflow past the top is visible.
    sum_ext = {1'b0, pos_q} + {1'b0, step_sz};
    diff    = pos_q - step_sz;

    if (dir) begin
      pos_step = (sum_ext > C_POS_MAX_X) ? C_POS_MAX : sum_ext[POS_WIDTH-1:0];
    end else begin
      pos_step = (pos_q < step_sz) ? '0 : diff;
    end

    pos_d = pos_q;
    if (legal) begin
      pos_d = pos_step;
    end

    prev_d = prev_q;
    if (load_init) begin
      prev_d = sync2_q;
    end else if (decode) begin
      prev_d = filt_q;
    end

    ivl_d = ivl_q;
    if (legal) begin
      ivl_d = '0;
    end else if (ivl_q < C_FAST_WIN) begin
      ivl_d = ivl_q + C_IVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q       <= '0;
      prev_q       <= '0;
      ivl_q        <= '0;
      pos_q        <= C_POS_RESET;
      pos_frame_q  <= C_POS_RESET;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      filt_q       <= filt_d;
      prev_q       <= prev_d;
      ivl_q        <= ivl_d;
      pos_q        <= pos_d;
      step_valid_q <= legal;
      // Frame copy takes the position as it stood before this cycle's step.
      if (frame_strobe) begin
        pos_frame_q <= pos_q;
      end
      if (legal) begin
        step_dir_q <= dir;
      end
      // A new illegal transition beats a coincident clear.
      if (illegal) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign paddle_pos       = pos_q;
  assign paddle_pos_frame = pos_frame_q;
  assign step_valid       = step_valid_q;
  assign step_dir         = step_dir_q;
  assign quad_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_paddle_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quad_paddle_decoder
//  Purpose  : Directed self-checking bench for quad_paddle_decoder. Two
//             instances share all inputs: one with default parameters and
//             one with FAST_WINDOW = 64 for the acceleration checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_quad_paddle_decoder;

  logic       clk;
  logic       rstn;
  logic       qa, qb;
  logic       frame_strobe;
  logic       err_clr;

  logic [8:0] pos1, frame1, pos2, frame2;
  logic       sv1, dir1, err1, sv2, dir2, err2;

  int         n_checks;
  int         n_fail;
  int         sv_cnt1;
  int         dbl_cnt;
  logic       sv1_d;
  logic       sel;

  logic [8:0] pos_sel;
  logic       sv_sel, dir_sel;

  assign pos_sel = sel ? pos2 : pos1;
  assign sv_sel  = sel ? sv2  : sv1;
  assign dir_sel = sel ? dir2 : dir1;

  quad_paddle_decoder u_dut (
    .clk              (clk),
    .resetn           (rstn),
    .quad_a           (qa),
    .quad_b           (qb),
    .frame_strobe     (frame_strobe),
    .err_clr          (err_clr),
    .paddle_pos       (pos1),
    .paddle_pos_frame (frame1),
    .step_valid       (sv1),
    .step_dir         (dir1),
    .quad_err         (err1)
  );

  quad_paddle_decoder #(.FAST_WINDOW(64)) u_dut_fast (
    .clk              (clk),
    .resetn           (rstn),
    .quad_a           (qa),
    .quad_b           (qb),
    .frame_strobe     (frame_strobe),
    .err_clr          (err_clr),
    .paddle_pos       (pos2),
    .paddle_pos_frame (frame2),
    .step_valid       (sv2),
    .step_dir         (dir2),
    .quad_err         (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter and back-to-back detector for the default instance.
  initial sv1_d = 1'b0;
  always @(negedge clk) begin
    sv1_d <= sv1;
    if (sv1) sv_cnt1 <= sv_cnt1 + 1;
    if (sv1 && sv1_d) dbl_cnt <= dbl_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Called right after a negedge. Input change is sampled at edge k; the
  // position must be unchanged after k+5 and updated after k+6.
  task automatic do_step(input logic [1:0] ab, input int old_pos, input int new_pos,
                         input logic exp_dir, input int hold);
    {qa, qb} = ab;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_pos", pos_sel, old_pos);
    check("pre_sv", sv_sel, 0);
    @(posedge clk);
    @(negedge clk);
    check("step_pos", pos_sel, new_pos);
    check("step_sv", sv_sel, 1);
    check("step_dir", dir_sel, exp_dir);
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    {qa, qb} = ab;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         base;
    logic [1:0] cur;

    n_checks     = 0;
    n_fail       = 0;
    sel          = 1'b0;
    qa           = 1'b1;
    qb           = 1'b1;
    frame_strobe = 1'b0;
    err_clr      = 1'b0;
    rstn         = 1'b0;

    // ---- Reset with 11 held, INIT must not produce steps or errors ----
    repeat (3) @(negedge clk);
    check("rst_pos", pos1, 0);
    check("rst_frame", frame1, 0);
    check("rst_sv", sv1, 0);
    check("rst_dir", dir1, 0);
    check("rst_err", err1, 0);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("init_pos", pos1, 0);
    check("init_err", err1, 0);
    check("init_sv_cnt", sv_cnt1, 0);

    // ---- Forward sequence, 6-edge latency on each step ----
    do_reset(2'b00);
    base = sv_cnt1;
    do_step(2'b01, 0, 1, 1'b1, 13);
    do_step(2'b11, 1, 2, 1'b1, 13);
    do_step(2'b10, 2, 3, 1'b1, 13);
    do_step(2'b00, 3, 4, 1'b1, 13);
    check("fwd_pulses", sv_cnt1 - base, 4);

    // ---- Glitches of 3 cycles are filtered out ----
    base = sv_cnt1;
    qa = 1'b1; repeat (3) @(negedge clk); qa = 1'b0; repeat (15) @(negedge clk);
    qb = 1'b1; repeat (3) @(negedge clk); qb = 1'b0; repeat (15) @(negedge clk);
    check("glitch_pos", pos1, 4);
    check("glitch_pulses", sv_cnt1 - base, 0);

    // ---- Lower saturation: reverse steps at 0 still pulse ----
    do_reset(2'b00);
    base = sv_cnt1;
    do_step(2'b10, 0, 0, 1'b0, 5);
    do_step(2'b11, 0, 0, 1'b0, 5);
    do_step(2'b01, 0, 0, 1'b0, 5);
    check("rev_pulses", sv_cnt1 - base, 3);

    // ---- Upper saturation: 600 forward steps ----
    cur  = 2'b01;
    base = sv_cnt1;
    for (int i = 0; i < 600; i++) begin
      cur = fwd(cur);
      {qa, qb} = cur;
      repeat (8) @(negedge clk);
    end
    check("sat_pos", pos1, 511);
    check("sat_pulses", sv_cnt1 - base, 600);
    check("sat_dir", dir1, 1);

    // ---- Illegal transition, clear, and set-beats-clear ----
    base = sv_cnt1;
    {qa, qb} = 2'b10;
    repeat (10) @(negedge clk);
    check("ill_err", err1, 1);
    check("ill_pos", pos1, 511);
    check("ill_pulses", sv_cnt1 - base, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", err1, 0);
    {qa, qb} = 2'b01;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("ill2_pre_err", err1, 0);
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    check("ill2_err", err1, 1);
    check("ill2_pos", pos1, 511);
    check("ill2_pulses", sv_cnt1 - base, 0);

    // ---- Frame latch takes the pre-step value ----
    check("frame_idle", frame1, 0);
    {qa, qb} = 2'b00;
    repeat (6) @(posedge clk);
    @(negedge clk);
    frame_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_strobe = 1'b0;
    check("frame_val", frame1, 511);
    check("frame_pos", pos1, 510);
    check("frame_sv", sv1, 1);
    repeat (5) @(negedge clk);
    check("frame_hold", frame1, 511);
    frame_strobe = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b0;
    check("frame_new", frame1, 510);

    // ---- Acceleration on the FAST_WINDOW=64 instance ----
    do_reset(2'b00);
    sel = 1'b1;
    do_step(2'b01, 0, 1, 1'b1, 3);   // previous dir after reset is 0
    do_step(2'b11, 1, 3, 1'b1, 3);
    do_step(2'b10, 3, 5, 1'b1, 3);
    repeat (80) @(negedge clk);      // interval counter saturates
    do_step(2'b00, 5, 6, 1'b1, 0);
    do_step(2'b01, 6, 8, 1'b1, 3);
    do_step(2'b00, 8, 7, 1'b0, 3);   // direction change: single step
    do_step(2'b01, 7, 8, 1'b1, 3);
    frame_strobe = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b0;
    check("fast_frame", frame2, 8);

    // ---- Reset in the middle of a step ----
    base = sv_cnt1;
    {qa, qb} = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_pos", pos2, 0);
    check("mid_rst_frame", frame2, 0);
    check("mid_rst_dir", dir2, 0);
    check("mid_rst_sv", sv2, 0);
    check("mid_rst_err", err2, 0);
    check("mid_rst_pos1", pos1, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_pos", pos2, 0);
    check("post_rst_pulses", sv_cnt1 - base, 0);

    check("no_back_to_back", dbl_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
